// File: rtl/serial_add_scheduler.sv
// serial_add_scheduler
//   Shares one bit-serial full-adder among NUM_REQ requesters. A round-robin
//   arbiter accepts one operand pair at a time, the adder walks the operands
//   LSB-first over WIDTH cycles, and the result goes back on a single
//   valid/ready response channel tagged with the requester index.
//
// Ports
//   clk, rst_n   clock (rising edge) and asynchronous active-low reset
//   req_valid    per-requester request
//   req_a/req_b  packed operands, requester i at [i*WIDTH +: WIDTH]
//   req_ready    one-hot grant, only ever driven in IDLE
//   rsp_valid    response available
//   rsp_ready    consumer accepts the response
//   rsp_id       requester that owns the response
//   rsp_sum      (a+b) mod 2^WIDTH
//   rsp_cout     carry out of bit WIDTH-1
//   busy         high whenever the FSM is not in IDLE
//
// state  | meaning
// -------+--------------------------------------------------------------
// S_IDLE | arbitrating; combinational grant, accept on handshake edge
// S_ADD  | one sum bit per cycle, LSB first, WIDTH cycles
// S_RESP | result presented, held until rsp_ready

module serial_add_scheduler #(
  parameter  int NUM_REQ = 4,
  parameter  int WIDTH   = 8,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [ID_W-1:0]          rsp_id,
  output logic [WIDTH-1:0]         rsp_sum,
  output logic                     rsp_cout,
  output logic                     busy
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int IDX_W = ID_W + 1;
  localparam logic [IDX_W-1:0] NREQ_EXT = IDX_W'(NUM_REQ);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADD  = 2'd1,
    S_RESP = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [ID_W-1:0]   ptr_q,   ptr_d;
  logic [ID_W-1:0]   id_q,    id_d;
  logic [WIDTH-1:0]  a_q,     a_d;
  logic [WIDTH-1:0]  b_q,     b_d;
  logic [WIDTH-1:0]  sum_q,   sum_d;
  logic              carry_q, carry_d;
  logic [CNT_W-1:0]  cnt_q,   cnt_d;

  logic              grant_found;
  logic [ID_W-1:0]   grant_id;
  logic              s_bit;
  logic              c_next;

  // Round-robin search starting at ptr_q. Walking offsets from the far end
  // down to zero lets the closest valid requester win by being written last.
  always_comb begin
    grant_found = 1'b0;
    grant_id    = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      logic [IDX_W-1:0] idx;
      idx = {1'b0, ptr_q} + IDX_W'(k);
      if (idx >= NREQ_EXT) idx = idx - NREQ_EXT;
      if (req_valid[idx[ID_W-1:0]]) begin
        grant_found = 1'b1;
        grant_id    = idx[ID_W-1:0];
      end
    end
  end

  // Operand registers shift right each ADD cycle, so bit 0 is always the
  // current bit; the sum shifts in from the top and ends LSB-aligned.
  assign s_bit  = a_q[0] ^ b_q[0] ^ carry_q;
  assign c_next = (a_q[0] & b_q[0]) | (a_q[0] & carry_q) | (b_q[0] & carry_q);

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    id_d      = id_q;
    a_d       = a_q;
    b_d       = b_q;
    sum_d     = sum_q;
    carry_d   = carry_q;
    cnt_d     = cnt_q;
    req_ready = '0;

    case (state_q)
      S_IDLE: begin
        // Gated by rst_n so no grant is visible while reset is held.
        if (grant_found && rst_n) begin
          req_ready = NUM_REQ'(1) << grant_id;
          id_d      = grant_id;
          a_d       = req_a[int'(grant_id)*WIDTH +: WIDTH];
          b_d       = req_b[int'(grant_id)*WIDTH +: WIDTH];
          sum_d     = '0;
          carry_d   = 1'b0;
          cnt_d     = CNT_W'(WIDTH - 1);
          if (grant_id == ID_W'(NUM_REQ - 1)) ptr_d = '0;
          else                                ptr_d = grant_id + ID_W'(1);
          state_d   = S_ADD;
        end
      end

      S_ADD: begin
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        sum_d   = (sum_q >> 1) | (WIDTH'(s_bit) << (WIDTH - 1));
        carry_d = c_next;
        // Terminal count: the edge that consumes the last bit leaves ADD.
        if (cnt_q == '0) state_d = S_RESP;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end

      S_RESP: begin
        if (rsp_ready) state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      id_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
    end
  end

  // Result registers are only touched in IDLE/ADD, so they are naturally
  // stable for as long as the FSM sits in RESP.
  assign rsp_valid = (state_q == S_RESP);
  assign rsp_id    = id_q;
  assign rsp_sum   = sum_q;
  assign rsp_cout  = carry_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_serial_add_scheduler.sv
module tb_serial_add_scheduler;

  localparam int NUM_REQ = 4;
  localparam int WIDTH   = 8;

  logic                     clk;
  logic                     rst_n;
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ*WIDTH-1:0] req_a;
  logic [NUM_REQ*WIDTH-1:0] req_b;
  logic [NUM_REQ-1:0]       req_ready;
  logic                     rsp_valid;
  logic                     rsp_ready;
  logic [1:0]               rsp_id;
  logic [WIDTH-1:0]         rsp_sum;
  logic                     rsp_cout;
  logic                     busy;

  int total = 0;
  int bad   = 0;

  serial_add_scheduler #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_sum   (rsp_sum),
    .rsp_cout  (rsp_cout),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Every task starts and ends shortly after a rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int id, input logic [7:0] a, input logic [7:0] b);
    req_a[id*WIDTH +: WIDTH] = a;
    req_b[id*WIDTH +: WIDTH] = b;
  endtask

  task automatic apply_reset(input logic [3:0] v);
    rst_n     = 1'b0;
    req_valid = v;
    rsp_ready = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  function automatic int oh2i(input logic [3:0] v);
    oh2i = -1;
    if ($countones(v) == 1)
      for (int i = 0; i < 4; i++) if (v[i]) oh2i = i;
  endfunction

  // Drives one isolated request, lets it complete, and reports observations.
  task automatic run_single(input int id, input logic [7:0] a, input logic [7:0] b,
                            output logic [3:0] grant, output int lat,
                            output logic [7:0] s, output logic c,
                            output logic [1:0] rid, output bit busy_ok);
    set_op(id, a, b);
    req_valid = 4'(1) << id;
    rsp_ready = 1'b0;
    #1;
    grant = req_ready;
    tick();
    req_valid = '0;
    set_op(id, 8'($urandom), 8'($urandom));
    busy_ok = 1'b1;
    lat = 0;
    while (!rsp_valid && lat < 40) begin
      if (!busy) busy_ok = 1'b0;
      tick();
      lat++;
    end
    if (!busy) busy_ok = 1'b0;
    s   = rsp_sum;
    c   = rsp_cout;
    rid = rsp_id;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    req_valid = 4'hF;
    #1;
    total++; if (req_ready !== 4'b0)  begin bad++; $display("FAIL reset_req_ready got=%b want=0000", req_ready); end
    total++; if (rsp_valid !== 1'b0)  begin bad++; $display("FAIL reset_rsp_valid got=%b want=0", rsp_valid); end
    total++; if (busy !== 1'b0)       begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if ({rsp_id, rsp_sum, rsp_cout} !== 11'b0)
      begin bad++; $display("FAIL reset_rsp_fields got id=%0d sum=%h cout=%b want 0", rsp_id, rsp_sum, rsp_cout); end
    tick();
    req_valid = '0;
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_single();
    logic [3:0] g; int lat; logic [7:0] s; logic c; logic [1:0] rid; bit bok;
    run_single(0, 8'h35, 8'h1A, g, lat, s, c, rid, bok);
    total++; if (g !== 4'b0001) begin bad++; $display("FAIL single_grant got=%b want=0001", g); end
    total++; if (lat !== 8)     begin bad++; $display("FAIL single_latency got=%0d want=8", lat); end
    total++; if ({c, s} !== 9'h04F) begin bad++; $display("FAIL single_sum got=%b_%h want=0_4f", c, s); end
    total++; if (rid !== 2'd0)  begin bad++; $display("FAIL single_id got=%0d want=0", rid); end
    total++; if (!bok)          begin bad++; $display("FAIL single_busy got=low want=high during op"); end
    total++; if (busy !== 1'b0 || rsp_valid !== 1'b0)
      begin bad++; $display("FAIL single_after got busy=%b rsp_valid=%b want 0 0", busy, rsp_valid); end
  endtask

  task automatic test_wrap();
    logic [3:0] g; int lat; logic [7:0] s; logic c; logic [1:0] rid; bit bok;
    run_single(2, 8'hFF, 8'h01, g, lat, s, c, rid, bok);
    total++; if ({c, s} !== 9'h100) begin bad++; $display("FAIL wrap_ff01 got=%b_%h want=1_00", c, s); end
    total++; if (rid !== 2'd2)      begin bad++; $display("FAIL wrap_id got=%0d want=2", rid); end
    run_single(2, 8'h80, 8'h80, g, lat, s, c, rid, bok);
    total++; if ({c, s} !== 9'h100) begin bad++; $display("FAIL wrap_8080 got=%b_%h want=1_00", c, s); end
  endtask

  // Collects n grants with valid mask v held; rsp_ready stays high.
  task automatic collect_grants(input logic [3:0] v, input int n, inout int ptr_m);
    int got_n, cyc, last_cyc, exp_g, gi;
    got_n = 0; cyc = 0; last_cyc = -1;
    rsp_ready = 1'b1;
    req_valid = v;
    #1;
    while (got_n < n && cyc < 200) begin
      if (req_ready !== 4'b0) begin
        exp_g = -1;
        for (int k = 0; k < 4; k++) if (exp_g < 0 && v[(ptr_m + k) % 4]) exp_g = (ptr_m + k) % 4;
        gi = oh2i(req_ready);
        total++; if (gi != exp_g) begin bad++; $display("FAIL rr_grant got=%b want_idx=%0d", req_ready, exp_g); end
        if (last_cyc >= 0) begin
          total++; if (cyc - last_cyc != WIDTH + 2)
            begin bad++; $display("FAIL rr_spacing got=%0d want=%0d", cyc - last_cyc, WIDTH + 2); end
        end
        ptr_m = (exp_g + 1) % 4;
        last_cyc = cyc;
        got_n++;
      end
      tick();
      cyc++;
    end
    total++; if (got_n != n) begin bad++; $display("FAIL rr_timeout got=%0d grants want=%0d", got_n, n); end
  endtask

  task automatic test_round_robin();
    int ptr_m;
    for (int i = 0; i < 4; i++) set_op(i, 8'($urandom), 8'($urandom));
    apply_reset(4'hF);
    ptr_m = 0;
    collect_grants(4'hF, 4, ptr_m);
    collect_grants(4'b0101, 2, ptr_m);
    req_valid = '0;
    repeat (WIDTH + 4) tick();
    rsp_ready = 1'b0;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rr_drain got busy=%b want=0", busy); end
  endtask

  task automatic test_backpressure();
    logic [7:0] a0, b0, a1, b1; logic [8:0] e0, e1; int lat;
    a0 = 8'($urandom); b0 = 8'($urandom); a1 = 8'($urandom); b1 = 8'($urandom);
    e0 = {1'b0, a0} + {1'b0, b0};
    e1 = {1'b0, a1} + {1'b0, b1};
    set_op(0, a0, b0);
    rsp_ready = 1'b0;
    req_valid = 4'b0001;
    tick();
    set_op(1, a1, b1);
    req_valid = 4'b0010;
    lat = 0;
    while (!rsp_valid && lat < 40) begin tick(); lat++; end
    total++; if (lat != WIDTH) begin bad++; $display("FAIL bp_latency got=%0d want=%0d", lat, WIDTH); end
    for (int i = 0; i < 5; i++) begin
      total++;
      if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || {rsp_cout, rsp_sum} !== e0 || req_ready !== 4'b0) begin
        bad++;
        $display("FAIL bp_hold got v=%b id=%0d res=%h rdy=%b want v=1 id=0 res=%h rdy=0000",
                 rsp_valid, rsp_id, {rsp_cout, rsp_sum}, req_ready, e0);
      end
      tick();
    end
    rsp_ready = 1'b1;
    #1;
    total++; if (req_ready !== 4'b0) begin bad++; $display("FAIL bp_no_early_grant got=%b want=0000", req_ready); end
    tick();
    rsp_ready = 1'b0;
    #1;
    total++; if (rsp_valid !== 1'b0 || req_ready !== 4'b0010)
      begin bad++; $display("FAIL bp_after got v=%b rdy=%b want v=0 rdy=0010", rsp_valid, req_ready); end
    tick();
    req_valid = '0;
    lat = 0;
    while (!rsp_valid && lat < 40) begin tick(); lat++; end
    total++; if (rsp_id !== 2'd1 || {rsp_cout, rsp_sum} !== e1)
      begin bad++; $display("FAIL bp_req1 got id=%0d res=%h want id=1 res=%h", rsp_id, {rsp_cout, rsp_sum}, e1); end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset_mid_add();
    logic [7:0] a1, b1; logic [8:0] e1; int lat; bit early;
    a1 = 8'($urandom); b1 = 8'($urandom);
    e1 = {1'b0, a1} + {1'b0, b1};
    set_op(3, 8'($urandom), 8'($urandom));
    set_op(1, a1, b1);
    req_valid = 4'b1000;
    #1;
    total++; if (req_ready !== 4'b1000) begin bad++; $display("FAIL rst_mid_grant got=%b want=1000", req_ready); end
    tick();
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    total++;
    if (req_ready !== 4'b0 || rsp_valid !== 1'b0 || busy !== 1'b0 || {rsp_id, rsp_sum, rsp_cout} !== 11'b0) begin
      bad++;
      $display("FAIL rst_mid_outputs got rdy=%b v=%b busy=%b id=%0d sum=%h cout=%b want all 0",
               req_ready, rsp_valid, busy, rsp_id, rsp_sum, rsp_cout);
    end
    req_valid = 4'b1010;
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    total++; if (req_ready !== 4'b0010) begin bad++; $display("FAIL rst_mid_ptr got=%b want=0010", req_ready); end
    tick();
    req_valid = '0;
    lat = 0; early = 1'b0;
    while (!rsp_valid && lat < 40) begin tick(); lat++; end
    total++; if (lat != WIDTH) begin bad++; $display("FAIL rst_mid_latency got=%0d want=%0d", lat, WIDTH); end
    total++; if (rsp_id !== 2'd1 || {rsp_cout, rsp_sum} !== e1)
      begin bad++; $display("FAIL rst_mid_rsp got id=%0d res=%h want id=1 res=%h", rsp_id, {rsp_cout, rsp_sum}, e1); end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    repeat (3) begin
      if (rsp_valid) early = 1'b1;
      tick();
    end
    total++; if (early) begin bad++; $display("FAIL rst_mid_extra_rsp got=1 want=0"); end
  endtask

  // Random traffic against a transaction-level model: a single shared adder
  // that is free or owned, answers WIDTH edges after an accept, and a queue
  // of expected results.
  task automatic test_sweep();
    logic [7:0] pa[4];
    logic [7:0] pb[4];
    bit         pend[4];
    logic [8:0] q_res[$];
    int         q_id[$];
    int         ptr_m, cd, issued, done, cyc, g;
    bit         m_free;
    logic [3:0] exp_ready;
    logic       exp_rv;
    for (int i = 0; i < 4; i++) begin pend[i] = 1'b0; pa[i] = '0; pb[i] = '0; end
    ptr_m = 0; cd = 0; issued = 0; done = 0; cyc = 0; m_free = 1'b1;
    apply_reset(4'b0);
    while (done < 200 && cyc < 20000) begin
      for (int i = 0; i < 4; i++) begin
        if (!pend[i] && issued < 200 && $urandom_range(0, 3) == 0) begin
          pa[i] = 8'($urandom); pb[i] = 8'($urandom);
          pend[i] = 1'b1; issued++;
        end
        set_op(i, pa[i], pb[i]);
        req_valid[i] = pend[i];
      end
      rsp_ready = 1'($urandom_range(0, 1));
      #1;
      g = -1;
      if (m_free)
        for (int k = 0; k < 4; k++) if (g < 0 && pend[(ptr_m + k) % 4]) g = (ptr_m + k) % 4;
      exp_ready = (g >= 0) ? (4'(1) << g) : 4'b0;
      exp_rv = !m_free && cd == 0;
      total++; if (req_ready !== exp_ready) begin bad++; $display("FAIL sweep_grant cyc=%0d got=%b want=%b", cyc, req_ready, exp_ready); end
      total++; if (rsp_valid !== exp_rv)    begin bad++; $display("FAIL sweep_rsp_valid cyc=%0d got=%b want=%b", cyc, rsp_valid, exp_rv); end
      if (exp_rv && rsp_ready) begin
        total++;
        if (q_id.size() == 0) begin
          bad++; $display("FAIL sweep_queue_empty cyc=%0d", cyc);
        end else begin
          if (rsp_id !== 2'(q_id[0]) || {rsp_cout, rsp_sum} !== q_res[0]) begin
            bad++;
            $display("FAIL sweep_rsp cyc=%0d got id=%0d res=%h want id=%0d res=%h",
                     cyc, rsp_id, {rsp_cout, rsp_sum}, q_id[0], q_res[0]);
          end
          void'(q_id.pop_front());
          void'(q_res.pop_front());
        end
        done++;
        m_free = 1'b1;
      end else if (!m_free && cd > 0) begin
        cd--;
      end
      if (g >= 0) begin
        q_id.push_back(g);
        q_res.push_back({1'b0, pa[g]} + {1'b0, pb[g]});
        m_free = 1'b0;
        cd = WIDTH;
        ptr_m = (g + 1) % 4;
        pend[g] = 1'b0;
      end
      tick();
      cyc++;
    end
    total++; if (done != 200 || q_id.size() != 0)
      begin bad++; $display("FAIL sweep_count got done=%0d left=%0d want done=200 left=0", done, q_id.size()); end
    req_valid = '0;
    rsp_ready = 1'b0;
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b0;
    tick();
    tick();
    test_reset();
    test_single();
    test_wrap();
    test_round_robin();
    test_backpressure();
    test_reset_mid_add();
    test_sweep();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
